// File: rtl/snake_input_ctrl.sv
// Input conditioning for the snake game: 2-FF sync + debounce of buttons and pause,
// press-to-direction decode with reversal rejection and a one-deep turn buffer committed on i_Tick.
module snake_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter logic [1:0]  INIT_DIR        = 2'b11
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] i_Push,
  input  logic       i_Pause,
  input  logic       i_Tick,
  output logic [1:0] o_Dir,
  output logic       o_Dir_Valid,
  output logic       o_Pause,
  output logic       o_Pending
);

  localparam int unsigned N_IN = 5;
  localparam int unsigned PAUSE_IDX = 4;
  // Released level: buttons idle high, pause idle low.
  localparam logic [N_IN-1:0] REL_LVL  = 5'b01111;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0]  raw_c;
  logic [N_IN-1:0]  sync1_q, sync1_d;
  logic [N_IN-1:0]  sync2_q, sync2_d;
  logic [N_IN-1:0]  deb_q, deb_d;
  logic [N_IN-1:0]  flip_c;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [CNT_W-1:0] cnt_d [N_IN];

  logic [1:0] dir_q, dir_d;
  logic       dir_vld_q, dir_vld_d;
  logic [1:0] pend_dir_q, pend_dir_d;
  logic       pend_vld_q, pend_vld_d;

  logic       press_c;
  logic [1:0] press_dir_c;
  logic       paused_c;
  logic       commit_c;
  logic [1:0] dir_eff_c;
  logic       accept_c;

  assign raw_c    = {i_Pause, i_Push};
  assign paused_c = deb_q[PAUSE_IDX];

  // Synchronizer and per-input debounce counters.
  always_comb begin
    sync1_d = raw_c;
    sync2_d = sync1_q;
    flip_c  = '0;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          flip_c[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    deb_d = deb_q ^ flip_c;
  end

  // Press decode: a debounced 1->0 flip; lowest index wins on ties.
  always_comb begin
    press_c     = 1'b0;
    press_dir_c = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      if (flip_c[i] && deb_q[i]) begin
        press_c     = 1'b1;
        press_dir_c = 2'(i);
      end
    end
  end

  // Commit and acceptance; a same-cycle press is judged against the post-commit direction.
  always_comb begin
    commit_c   = i_Tick & pend_vld_q & ~paused_c;
    dir_eff_c  = commit_c ? pend_dir_q : dir_q;
    accept_c   = press_c & ~paused_c
               & (press_dir_c != dir_eff_c)
               & (press_dir_c != {dir_eff_c[1], ~dir_eff_c[0]});

    dir_d      = dir_eff_c;
    dir_vld_d  = commit_c;
    pend_dir_d = pend_dir_q;
    pend_vld_d = pend_vld_q;
    if (commit_c) begin
      pend_vld_d = 1'b0;
    end
    if (accept_c) begin
      pend_vld_d = 1'b1;
      pend_dir_d = press_dir_c;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q    <= REL_LVL;
      sync2_q    <= REL_LVL;
      deb_q      <= REL_LVL;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= '0;
      end
      dir_q      <= INIT_DIR;
      dir_vld_q  <= 1'b0;
      pend_dir_q <= INIT_DIR;
      pend_vld_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      dir_q      <= dir_d;
      dir_vld_q  <= dir_vld_d;
      pend_dir_q <= pend_dir_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign o_Dir       = dir_q;
  assign o_Dir_Valid = dir_vld_q;
  assign o_Pause     = paused_c;
  assign o_Pending   = pend_vld_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Bench for snake_input_ctrl: directed scenarios plus randomized traffic against a
// window-based behavioural model of debounce, press arbitration and turn buffering.
module tb_snake_input_ctrl;

  localparam int DC = 4;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [3:0] i_Push;
  logic       i_Pause;
  logic       i_Tick;
  logic [1:0] o_Dir;
  logic       o_Dir_Valid;
  logic       o_Pause;
  logic       o_Pending;

  int errors = 0;
  int checks = 0;

  snake_input_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (3),
    .INIT_DIR       (2'b11)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_Push     (i_Push),
    .i_Pause    (i_Pause),
    .i_Tick     (i_Tick),
    .o_Dir      (o_Dir),
    .o_Dir_Valid(o_Dir_Valid),
    .o_Pause    (o_Pause),
    .o_Pending  (o_Pending)
  );

  always #5 Clk = ~Clk;

  // Reference model state
  logic [4:0] m_s1, m_s2, m_lvl;
  logic [4:0] m_hist[$];
  logic [1:0] m_dir, m_pdir;
  logic       m_pv, m_dv;
  logic [1:0] opp_tab [4] = '{2'b01, 2'b00, 2'b11, 2'b10};

  // Debounced level flips once the last DC synchronized samples all disagree with it.
  task automatic model_edge();
    logic [4:0] raw;
    logic [4:0] new_lvl;
    int         press_idx;
    logic       commit;
    logic [1:0] d_eff;
    logic       accept;
    raw = {i_Pause, i_Push};
    if (Rst) begin
      m_s1 = 5'b01111; m_s2 = 5'b01111; m_lvl = 5'b01111;
      m_hist.delete();
      m_dir = 2'b11; m_pdir = 2'b11; m_pv = 1'b0; m_dv = 1'b0;
      return;
    end
    m_hist.push_back(m_s2);
    if (m_hist.size() > DC) void'(m_hist.pop_front());
    new_lvl = m_lvl;
    press_idx = -1;
    for (int i = 0; i < 5; i++) begin
      logic stable;
      stable = (m_hist.size() == DC);
      foreach (m_hist[h]) if (m_hist[h][i] == m_lvl[i]) stable = 1'b0;
      if (stable) begin
        new_lvl[i] = ~m_lvl[i];
        if (i < 4 && m_lvl[i] == 1'b1 && press_idx < 0) press_idx = i;
      end
    end
    commit = i_Tick && m_pv && !m_lvl[4];
    d_eff  = commit ? m_pdir : m_dir;
    accept = (press_idx >= 0) && !m_lvl[4] &&
             (2'(press_idx) != d_eff) && (2'(press_idx) != opp_tab[d_eff]);
    m_dv  = commit;
    m_dir = d_eff;
    if (commit) m_pv = 1'b0;
    if (accept) begin m_pv = 1'b1; m_pdir = 2'(press_idx); end
    m_lvl = new_lvl;
    m_s2  = m_s1;
    m_s1  = raw;
  endtask

  function automatic logic [4:0] mdl_vec();
    return {m_dir, m_dv, m_lvl[4], m_pv};
  endfunction

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge Clk);
      model_edge();
      #1;
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1; i_Push = 4'hF; i_Pause = 1'b0; i_Tick = 1'b0;
    step(2);
    Rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] mask);
    i_Push = mask;
    step(DC + 2);
    i_Push = 4'hF;
    step(DC + 2);
  endtask

  task automatic tick();
    i_Tick = 1'b1;
    step(1);
    i_Tick = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; i_Push = 4'hF; i_Pause = 1'b0; i_Tick = 1'b0;
    step(2);
    checks++;
    if ({o_Dir, o_Dir_Valid, o_Pause, o_Pending} !== 5'b11_0_0_0) begin
      errors++;
      $display("FAIL reset_state: got %b want 11000", {o_Dir, o_Dir_Valid, o_Pause, o_Pending});
    end
    Rst = 1'b0;
    i_Push = 4'b1110;
    step(DC + 2);
    checks++;
    if (o_Pending !== 1'b1) begin
      errors++; $display("FAIL reset_pend_setup: o_Pending=%b want 1", o_Pending);
    end
    Rst = 1'b1; i_Tick = 1'b1; i_Push = 4'hF;
    step(1);
    checks++;
    if ({o_Dir, o_Dir_Valid, o_Pending} !== 4'b11_0_0) begin
      errors++;
      $display("FAIL reset_over_commit: got dir=%b vld=%b pend=%b want 11 0 0", o_Dir, o_Dir_Valid, o_Pending);
    end
    Rst = 1'b0; i_Tick = 1'b0;
    step(1);
  endtask

  task automatic test_debounce_commit();
    do_reset();
    i_Push = 4'b1110;
    step(DC + 1);
    checks++;
    if (o_Pending !== 1'b0) begin
      errors++; $display("FAIL debounce_early: o_Pending=%b want 0", o_Pending);
    end
    step(1);
    checks++;
    if (o_Pending !== 1'b1) begin
      errors++; $display("FAIL debounce_latency: o_Pending=%b want 1", o_Pending);
    end
    tick();
    checks++;
    if ({o_Dir, o_Dir_Valid, o_Pending} !== 4'b00_1_0) begin
      errors++;
      $display("FAIL commit_up: got dir=%b vld=%b pend=%b want 00 1 0", o_Dir, o_Dir_Valid, o_Pending);
    end
    step(1);
    checks++;
    if ({o_Dir, o_Dir_Valid} !== 3'b00_0) begin
      errors++; $display("FAIL valid_one_cycle: got dir=%b vld=%b want 00 0", o_Dir, o_Dir_Valid);
    end
    i_Push = 4'hF;
    step(DC + 3);
    i_Push = 4'b1101;
    step(3);
    i_Push = 4'hF;
    step(10);
    checks++;
    if (o_Pending !== 1'b0) begin
      errors++; $display("FAIL glitch_reject: o_Pending=%b want 0", o_Pending);
    end
    tick();
    checks++;
    if ({o_Dir, o_Dir_Valid} !== 3'b00_0) begin
      errors++; $display("FAIL idle_tick: got dir=%b vld=%b want 00 0", o_Dir, o_Dir_Valid);
    end
  endtask

  task automatic test_reversal();
    do_reset();
    press(4'b1011);
    checks++;
    if (o_Pending !== 1'b0) begin
      errors++; $display("FAIL reversal_left: o_Pending=%b want 0", o_Pending);
    end
    press(4'b0111);
    checks++;
    if (o_Pending !== 1'b0) begin
      errors++; $display("FAIL same_dir_right: o_Pending=%b want 0", o_Pending);
    end
    press(4'b1101);
    checks++;
    if (o_Pending !== 1'b1) begin
      errors++; $display("FAIL down_accept: o_Pending=%b want 1", o_Pending);
    end
    tick();
    checks++;
    if ({o_Dir, o_Dir_Valid} !== 3'b01_1) begin
      errors++; $display("FAIL commit_down: got dir=%b vld=%b want 01 1", o_Dir, o_Dir_Valid);
    end
  endtask

  task automatic test_double_turn();
    do_reset();
    press(4'b1110);
    tick();
    press(4'b1011);
    press(4'b0111);
    checks++;
    if ({o_Dir, o_Pending} !== 3'b00_1) begin
      errors++; $display("FAIL buffer_hold: got dir=%b pend=%b want 00 1", o_Dir, o_Pending);
    end
    tick();
    checks++;
    if (o_Dir !== 2'b11) begin
      errors++; $display("FAIL last_press_wins: o_Dir=%b want 11", o_Dir);
    end
    press(4'b1101);
    press(4'b1110);
    tick();
    checks++;
    if (o_Dir !== 2'b00) begin
      errors++; $display("FAIL up_vs_committed: o_Dir=%b want 00", o_Dir);
    end
  endtask

  task automatic test_pause();
    do_reset();
    press(4'b1101);
    i_Pause = 1'b1;
    step(DC + 1);
    checks++;
    if (o_Pause !== 1'b0) begin
      errors++; $display("FAIL pause_early: o_Pause=%b want 0", o_Pause);
    end
    step(1);
    checks++;
    if (o_Pause !== 1'b1) begin
      errors++; $display("FAIL pause_latency: o_Pause=%b want 1", o_Pause);
    end
    press(4'b1110);
    tick();
    checks++;
    if ({o_Dir, o_Dir_Valid, o_Pending} !== 4'b11_0_1) begin
      errors++;
      $display("FAIL pause_hold: got dir=%b vld=%b pend=%b want 11 0 1", o_Dir, o_Dir_Valid, o_Pending);
    end
    i_Pause = 1'b0;
    step(DC + 2);
    checks++;
    if (o_Pause !== 1'b0) begin
      errors++; $display("FAIL unpause: o_Pause=%b want 0", o_Pause);
    end
    tick();
    checks++;
    if ({o_Dir, o_Dir_Valid, o_Pending} !== 4'b01_1_0) begin
      errors++;
      $display("FAIL resume_commit: got dir=%b vld=%b pend=%b want 01 1 0", o_Dir, o_Dir_Valid, o_Pending);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    press(4'b1100);
    tick();
    checks++;
    if (o_Dir !== 2'b00) begin
      errors++; $display("FAIL lowest_wins: o_Dir=%b want 00", o_Dir);
    end
    do_reset();
    press(4'b1110);
    i_Push = 4'b1011;
    step(DC + 1);
    i_Tick = 1'b1;
    step(1);
    i_Tick = 1'b0;
    checks++;
    if ({o_Dir, o_Dir_Valid, o_Pending} !== 4'b00_1_1) begin
      errors++;
      $display("FAIL press_with_commit: got dir=%b vld=%b pend=%b want 00 1 1", o_Dir, o_Dir_Valid, o_Pending);
    end
    i_Push = 4'hF;
    step(DC + 2);
    tick();
    checks++;
    if (o_Dir !== 2'b10) begin
      errors++; $display("FAIL left_after_commit: o_Dir=%b want 10", o_Dir);
    end
  endtask

  task automatic test_random();
    int hold;
    int pause_left;
    do_reset();
    pause_left = 40;
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 3))
        0:       i_Push = 4'hF;
        1, 2:    i_Push = ~(4'b0001 << $urandom_range(0, 3));
        default: i_Push = 4'($urandom);
      endcase
      hold = $urandom_range(1, 12);
      for (int c = 0; c < hold; c++) begin
        i_Tick = ($urandom_range(0, 3) == 0);
        Rst    = ($urandom_range(0, 299) == 0);
        if (pause_left == 0) begin
          i_Pause = ~i_Pause;
          pause_left = $urandom_range(20, 80);
        end else begin
          pause_left--;
        end
        step(1);
        checks++;
        if ({o_Dir, o_Dir_Valid, o_Pause, o_Pending} !== mdl_vec()) begin
          errors++;
          $display("FAIL random_cycle it=%0d: got %b want %b (dir,vld,pause,pend)",
                   it, {o_Dir, o_Dir_Valid, o_Pause, o_Pending}, mdl_vec());
        end
      end
    end
    Rst = 1'b0; i_Tick = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; i_Push = 4'hF; i_Pause = 1'b0; i_Tick = 1'b0;
    test_reset();
    test_debounce_commit();
    test_reversal();
    test_double_turn();
    test_pause();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
